// File: rtl/ysyx_24080006_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_ifu_prefetch
//
// Sequential instruction prefetcher placed in front of a 32-bit instruction
// FIFO. It issues word fetches on a valid/ready read bus, pushes in-order
// responses straight into the FIFO, and limits issue with a credit check so
// the FIFO cannot overflow. A redirect flushes the FIFO, restarts fetch at the
// new word address and drops every response that is still in flight.
//
// Optional build macro:
//   YSYX_24080006_PF_PERF_EN - adds pf_stall_cnt, a saturating count of RUN
//                              cycles lost to exhausted credit.
//
// Ports:
//   clock, reset           clock and asynchronous active-low reset
//   redirect_valid/_pc     one-cycle restart request and its address
//   req_valid/_ready/_addr read request channel
//   rsp_valid/_data/_err   in-order read response channel (always accepted)
//   fifo_wren/_wdata       FIFO push
//   fifo_flush             FIFO flush (redirect cycle)
//   fifo_full              FIFO full flag
//   fifo_data_avail        FIFO occupancy
//   fetch_err              sticky bus-error flag, cleared by a redirect
//   pf_stall_cnt           (optional) credit-stall cycle counter
//
// Request channel: a transfer happens on a cycle where req_valid && req_ready.
// Once req_valid is raised it stays high with req_addr unchanged until that
// transfer happens, whatever else (redirect, error, credit) occurs meanwhile.
// ---------------------------------------------------------------------------
module ysyx_24080006_ifu_prefetch #(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1,
    parameter int AVAIL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [31:0]        req_addr,
    input  logic               rsp_valid,
    input  logic [31:0]        rsp_data,
    input  logic               rsp_err,
    output logic               fifo_wren,
    output logic [31:0]        fifo_wdata,
    output logic               fifo_flush,
    input  logic               fifo_full,
    input  logic [AVAIL_W-1:0] fifo_data_avail,
    output logic               fetch_err
`ifdef YSYX_24080006_PF_PERF_EN
    ,
    output logic [31:0]        pf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Credit sum is one bit wider than its widest operand so it cannot wrap.
    localparam int SUM_W = ((CNT_W > AVAIL_W) ? CNT_W : AVAIL_W) + 1;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      hold_addr_q, hold_addr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             held_q, held_d;
    logic             held_stale_q, held_stale_d;
    logic             fetch_err_q, fetch_err_d;

    logic [SUM_W-1:0] credit_sum;
    logic             credit_ok;
    logic             hs;
    logic             stale_hs;
    logic             rsp_drop;
    logic             rsp_fault;

    assign credit_sum = SUM_W'(outstanding_q) + SUM_W'(fifo_data_avail);
    // fifo_full is implied by the occupancy term; it is kept as a cheap guard.
    assign credit_ok  = (outstanding_q < CNT_W'(MAX_OUTSTANDING)) &&
                        (credit_sum < SUM_W'(FIFO_DEPTH)) && !fifo_full;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_addr_d   = hold_addr_q;
        discard_d     = discard_q;
        fetch_err_d   = fetch_err_q;

        // A held request wins over any new issue decision.
        req_valid  = held_q || ((state_q == ST_RUN) && credit_ok && !redirect_valid);
        req_addr   = held_q ? hold_addr_q : pc_q;
        hs         = req_valid && req_ready;
        // A held request that survived a redirect fetches a dead address.
        stale_hs   = hs && held_q && held_stale_q;

        rsp_drop   = (discard_q != '0) || redirect_valid;
        fifo_wren  = rsp_valid && !rsp_drop && (state_q == ST_RUN) && !rsp_err;
        rsp_fault  = rsp_valid && !rsp_drop && rsp_err;
        fifo_wdata = rsp_data;
        fifo_flush = redirect_valid;

        outstanding_d = outstanding_q + CNT_W'(hs) - CNT_W'(rsp_valid);

        held_d       = req_valid && !req_ready;
        held_stale_d = held_d && ((held_q && held_stale_q) || redirect_valid);
        if (held_d) begin
            hold_addr_d = req_addr;
        end

        if (redirect_valid) begin
            pc_d        = redirect_pc & 32'hFFFF_FFFC;
            // Everything still in flight after this edge belongs to the old stream.
            discard_d   = outstanding_d;
            fetch_err_d = 1'b0;
            state_d     = ST_RUN;
        end else begin
            if (hs && !stale_hs) begin
                pc_d = pc_q + 32'd4;
            end
            discard_d = discard_q - CNT_W'(rsp_valid && (discard_q != '0)) + CNT_W'(stale_hs);
            if (rsp_fault) begin
                fetch_err_d = 1'b1;
                state_d     = ST_HALT;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            hold_addr_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            held_q        <= 1'b0;
            held_stale_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_addr_q   <= hold_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            held_q        <= held_d;
            held_stale_q  <= held_stale_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;

`ifdef YSYX_24080006_PF_PERF_EN
    logic [31:0] pf_stall_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pf_stall_cnt_q <= '0;
        end else if ((state_q == ST_RUN) && !held_q && !credit_ok &&
                     (pf_stall_cnt_q != 32'hFFFF_FFFF)) begin
            pf_stall_cnt_q <= pf_stall_cnt_q + 32'd1;
        end
    end

    assign pf_stall_cnt = pf_stall_cnt_q;
`endif

    // Discarded responses are always a subset of the in-flight ones.
    assert property (@(posedge clock) disable iff (!reset) discard_q <= outstanding_q);

endmodule
